// File: rtl/rf_wb_arbiter_if.sv
// Write-back arbiter bus: two producer handshakes, register-file write port,
// and the issue/flush/query side of the pending-write scoreboard.
interface rf_wb_arbiter_if #(
    parameter int NBITS = 32,
    parameter int AW    = 5
);
    logic             A_VALID;
    logic             A_READY;
    logic [AW-1:0]    A_ADDR;
    logic [NBITS-1:0] A_DATA;

    logic             B_VALID;
    logic             B_READY;
    logic [AW-1:0]    B_ADDR;
    logic [NBITS-1:0] B_DATA;

    logic             RF_ENABLE;
    logic             RF_WR;
    logic [AW-1:0]    RF_ADD_WR;
    logic [NBITS-1:0] RF_DATAIN;

    logic             ISSUE_VALID;
    logic [AW-1:0]    ISSUE_ADDR;
    logic             FLUSH;
    logic [AW-1:0]    QUERY_ADDR1;
    logic [AW-1:0]    QUERY_ADDR2;
    logic             QUERY_BUSY1;
    logic             QUERY_BUSY2;

    modport slave (
        input  A_VALID, A_ADDR, A_DATA,
        output A_READY,
        input  B_VALID, B_ADDR, B_DATA,
        output B_READY,
        output RF_ENABLE, RF_WR, RF_ADD_WR, RF_DATAIN,
        input  ISSUE_VALID, ISSUE_ADDR, FLUSH, QUERY_ADDR1, QUERY_ADDR2,
        output QUERY_BUSY1, QUERY_BUSY2
    );

    modport master (
        output A_VALID, A_ADDR, A_DATA,
        input  A_READY,
        output B_VALID, B_ADDR, B_DATA,
        input  B_READY,
        input  RF_ENABLE, RF_WR, RF_ADD_WR, RF_DATAIN,
        output ISSUE_VALID, ISSUE_ADDR, FLUSH, QUERY_ADDR1, QUERY_ADDR2,
        input  QUERY_BUSY1, QUERY_BUSY2
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register-file write port, with an
// optional pending-write scoreboard enabled by RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter #(
    parameter int NBITS      = 32,
    parameter int NREGISTERS = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    rf_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(NREGISTERS);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    last_t            last, last_next;
    logic             grant_a, grant_b, xfer;
    logic [AW-1:0]    win_addr;
    logic [NBITS-1:0] win_data;

    logic             rf_wr;
    logic             rf_enable;
    logic [AW-1:0]    rf_addr;
    logic [NBITS-1:0] rf_data;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last <= LAST_B;
        end else begin
            last <= last_next;
        end
    end

    // READY is gated by RESET so no grant is visible while reset is held
    always_comb begin
        grant_a   = RESET && bus.A_VALID && (!bus.B_VALID || last == LAST_B);
        grant_b   = RESET && bus.B_VALID && (!bus.A_VALID || last == LAST_A);
        xfer      = grant_a || grant_b;
        last_next = last;
        win_addr  = bus.B_ADDR;
        win_data  = bus.B_DATA;
        if (grant_a) begin
            last_next = LAST_A;
            win_addr  = bus.A_ADDR;
            win_data  = bus.A_DATA;
        end else if (grant_b) begin
            last_next = LAST_B;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rf_wr     <= 1'b0;
            rf_enable <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
        end else begin
            rf_enable <= 1'b1;
            rf_wr     <= xfer && (win_addr != '0);
            if (xfer) begin
                rf_addr <= win_addr;
                rf_data <= win_data;
            end
        end
    end

    assign bus.A_READY   = grant_a;
    assign bus.B_READY   = grant_b;
    assign bus.RF_WR     = rf_wr;
    assign bus.RF_ENABLE = rf_enable;
    assign bus.RF_ADD_WR = rf_addr;
    assign bus.RF_DATAIN = rf_data;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREGISTERS-1:0] busy, busy_next;

    // Order matters: issue beats the write-back clear, flush beats everything
    always_comb begin
        busy_next = busy;
        if (rf_wr) begin
            busy_next[rf_addr] = 1'b0;
        end
        if (bus.ISSUE_VALID) begin
            busy_next[bus.ISSUE_ADDR] = 1'b1;
        end
        if (bus.FLUSH) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign bus.QUERY_BUSY1 = busy[bus.QUERY_ADDR1];
    assign bus.QUERY_BUSY2 = busy[bus.QUERY_ADDR2];
`else
    logic unused_sb;
    assign unused_sb = ^{bus.ISSUE_VALID, bus.ISSUE_ADDR, bus.FLUSH,
                         bus.QUERY_ADDR1, bus.QUERY_ADDR2};

    assign bus.QUERY_BUSY1 = 1'b0;
    assign bus.QUERY_BUSY2 = 1'b0;
`endif
endmodule
